// File: rtl/dsram_ctrl_pkg.sv
// rtl/dsram_ctrl_pkg.sv - shared types, widths and grant helpers for the dsram sequencer
package dsram_ctrl_pkg;

    localparam int LINE_W = 256;
    localparam int WORD_W = 32;
    localparam int OFF_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        MRG  = 2'd2,
        FWR  = 2'd3
    } state_t;

    // Values double as bit positions in the request/grant vectors.
    typedef enum logic [1:0] {
        REQ_CORE  = 2'd0,
        REQ_FILL  = 2'd1,
        REQ_EVICT = 2'd2
    } req_t;

    function automatic logic [2:0] req_bit(input req_t r);
        return 3'b001 << r;
    endfunction

    // One-hot grant for the first requester, in the order given, that is asserting.
    function automatic logic [2:0] prio_pick(input logic [2:0] req,
                                             input req_t p0,
                                             input req_t p1,
                                             input req_t p2);
        if (|(req & req_bit(p0))) return req_bit(p0);
        if (|(req & req_bit(p1))) return req_bit(p1);
        if (|(req & req_bit(p2))) return req_bit(p2);
        return 3'b000;
    endfunction

endpackage

// File: rtl/dsram_ctrl_arb.sv
// rtl/dsram_ctrl_arb.sv - 3-way grant logic; fixed priority, or round robin with DSRAM_CTRL_RR_ARB_EN
module dsram_ctrl_arb
    import dsram_ctrl_pkg::*;
(
`ifdef DSRAM_CTRL_RR_ARB_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic [2:0] req,
    input  logic       en,
    output logic [2:0] gnt
);

`ifdef DSRAM_CTRL_RR_ARB_EN
    req_t       last_q;
    logic [2:0] pick;

    // Rotate the priority ring fill -> evict -> core to start just after the last grantee.
    always_comb begin
        pick = 3'b000;
        case (last_q)
            REQ_FILL:  pick = prio_pick(req, REQ_EVICT, REQ_CORE,  REQ_FILL);
            REQ_EVICT: pick = prio_pick(req, REQ_CORE,  REQ_FILL,  REQ_EVICT);
            default:   pick = prio_pick(req, REQ_FILL,  REQ_EVICT, REQ_CORE);
        endcase
    end

    assign gnt = en ? pick : 3'b000;

    // Remember who was accepted last; starting at core makes fill the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_CORE;
        end else if (gnt[REQ_FILL]) begin
            last_q <= REQ_FILL;
        end else if (gnt[REQ_EVICT]) begin
            last_q <= REQ_EVICT;
        end else if (gnt[REQ_CORE]) begin
            last_q <= REQ_CORE;
        end
    end
`else
    assign gnt = en ? prio_pick(req, REQ_FILL, REQ_EVICT, REQ_CORE) : 3'b000;
`endif

endmodule

// File: rtl/dsram_ctrl.sv
// rtl/dsram_ctrl.sv - dsram sequencer/arbiter for core RMW, fill and evict; DSRAM_CTRL_RR_ARB_EN selects round robin
module dsram_ctrl
    import dsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_valid,
    output logic                  core_ready,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_idx,
    input  logic [OFF_W-1:0]      core_offset,
    input  logic [3:0]            core_be,
    input  logic [WORD_W-1:0]     core_wd,
    output logic                  core_rsp_valid,
    output logic [WORD_W-1:0]     core_rsp_rd,
    input  logic                  fill_valid,
    output logic                  fill_ready,
    input  logic [ADDR_WIDTH-1:0] fill_idx,
    input  logic [LINE_W-1:0]     fill_wd,
    output logic                  fill_done,
    input  logic                  evict_valid,
    output logic                  evict_ready,
    input  logic [ADDR_WIDTH-1:0] evict_idx,
    output logic                  evict_rsp_valid,
    output logic [LINE_W-1:0]     evict_rsp_rd,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [OFF_W-1:0]      ram_offset,
    output logic [3:0]            ram_be,
    output logic [LINE_W-1:0]     ram_wd,
    output logic                  ram_fill,
    output logic                  ram_write,
    output logic                  ram_read,
    input  logic [LINE_W-1:0]     ram_rd
);

    state_t              state;
    req_t                cur_req;
    logic                op_we;
    logic [WORD_W-1:0]   wd_q;
    logic [LINE_W-1:0]   ram_wd_q;
    logic                rsp_load_q;
    logic [WORD_W-1:0]   core_rsp_hold;
    logic [LINE_W-1:0]   evict_rsp_hold;
    logic [2:0]          req;
    logic [2:0]          gnt;
    logic                idle;
    logic [WORD_W-1:0]   word_sel;
    logic [WORD_W-1:0]   be_mask;
    logic [WORD_W-1:0]   word_new;
    logic [LINE_W-1:0]   line_merged;

    assign idle = (state == IDLE);
    assign req  = {evict_valid, fill_valid, core_valid};

    dsram_ctrl_arb u_arb (
`ifdef DSRAM_CTRL_RR_ARB_EN
        .clk   (clk),
        .rst_n (rst_n),
`endif
        .req   (req),
        .en    (idle),
        .gnt   (gnt)
    );

    assign core_ready  = gnt[REQ_CORE];
    assign fill_ready  = gnt[REQ_FILL];
    assign evict_ready = gnt[REQ_EVICT];

    // ram_rd is only trustworthy in the cycle after ram_read, which is when these are consumed.
    assign word_sel = ram_rd[{ram_offset, 5'b00000} +: WORD_W];
    assign be_mask  = {{8{ram_be[3]}}, {8{ram_be[2]}}, {8{ram_be[1]}}, {8{ram_be[0]}}};
    assign word_new = (word_sel & ~be_mask) | (wd_q & be_mask);

    // Splice the merged word back into the line just read for the store write-back.
    always_comb begin
        line_merged = ram_rd;
        line_merged[{ram_offset, 5'b00000} +: WORD_W] = word_new;
    end

    assign ram_wd = (state == MRG && cur_req == REQ_CORE) ? line_merged : ram_wd_q;

    // Response data is live from the array during the pulse and held afterwards.
    assign core_rsp_rd  = core_rsp_valid  ? (rsp_load_q ? word_sel : '0) : core_rsp_hold;
    assign evict_rsp_rd = evict_rsp_valid ? ram_rd : evict_rsp_hold;

    // Sequencer: accept the arbitration winner in IDLE, then walk its read/merge/write steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cur_req        <= REQ_CORE;
            op_we          <= 1'b0;
            wd_q           <= '0;
            ram_wd_q       <= '0;
            rsp_load_q     <= 1'b0;
            core_rsp_hold  <= '0;
            evict_rsp_hold <= '0;
            ram_a          <= '0;
            ram_offset     <= '0;
            ram_be         <= '0;
            ram_fill       <= 1'b0;
            ram_write      <= 1'b0;
            ram_read       <= 1'b0;
            fill_done      <= 1'b0;
            core_rsp_valid <= 1'b0;
            evict_rsp_valid <= 1'b0;
        end else begin
            ram_read        <= 1'b0;
            ram_write       <= 1'b0;
            ram_fill        <= 1'b0;
            fill_done       <= 1'b0;
            core_rsp_valid  <= 1'b0;
            evict_rsp_valid <= 1'b0;

            if (core_rsp_valid) begin
                core_rsp_hold <= core_rsp_rd;
            end
            if (evict_rsp_valid) begin
                evict_rsp_hold <= evict_rsp_rd;
            end

            case (state)
                IDLE: begin
                    if (fill_ready) begin
                        ram_a     <= fill_idx;
                        ram_wd_q  <= fill_wd;
                        ram_write <= 1'b1;
                        ram_fill  <= 1'b1;
                        fill_done <= 1'b1;
                        state     <= FWR;
                    end else if (evict_ready) begin
                        ram_a    <= evict_idx;
                        cur_req  <= REQ_EVICT;
                        ram_read <= 1'b1;
                        state    <= RD;
                    end else if (core_ready) begin
                        ram_a      <= core_idx;
                        ram_offset <= core_offset;
                        ram_be     <= core_be;
                        wd_q       <= core_wd;
                        op_we      <= core_we;
                        cur_req    <= REQ_CORE;
                        ram_read   <= 1'b1;
                        state      <= RD;
                    end
                end
                RD: begin
                    if (cur_req == REQ_EVICT) begin
                        evict_rsp_valid <= 1'b1;
                        state           <= MRG;
                    end else if (op_we) begin
                        ram_write      <= 1'b1;
                        core_rsp_valid <= 1'b1;
                        rsp_load_q     <= 1'b0;
                        state          <= MRG;
                    end else begin
                        core_rsp_valid <= 1'b1;
                        rsp_load_q     <= 1'b1;
                        state          <= IDLE;
                    end
                end
                MRG: begin
                    state <= IDLE;
                end
                FWR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsram_ctrl.sv
// tb/tb_dsram_ctrl.sv - self-checking bench for dsram_ctrl against a line-level memory model
module tb_dsram_ctrl;

    logic         clk;
    logic         rst_n;
    logic         core_valid;
    logic         core_ready;
    logic         core_we;
    logic [12:0]  core_idx;
    logic [2:0]   core_offset;
    logic [3:0]   core_be;
    logic [31:0]  core_wd;
    logic         core_rsp_valid;
    logic [31:0]  core_rsp_rd;
    logic         fill_valid;
    logic         fill_ready;
    logic [12:0]  fill_idx;
    logic [255:0] fill_wd;
    logic         fill_done;
    logic         evict_valid;
    logic         evict_ready;
    logic [12:0]  evict_idx;
    logic         evict_rsp_valid;
    logic [255:0] evict_rsp_rd;
    logic [12:0]  ram_a;
    logic [2:0]   ram_offset;
    logic [3:0]   ram_be;
    logic [255:0] ram_wd;
    logic         ram_fill;
    logic         ram_write;
    logic         ram_read;
    logic [255:0] ram_rd;

    int tests = 0;
    int fails = 0;

    logic [255:0] dsram [0:15];
    logic [255:0] ref_mem [0:15];

    dsram_ctrl #(.ADDR_WIDTH(13)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_valid(core_valid), .core_ready(core_ready), .core_we(core_we),
        .core_idx(core_idx), .core_offset(core_offset), .core_be(core_be), .core_wd(core_wd),
        .core_rsp_valid(core_rsp_valid), .core_rsp_rd(core_rsp_rd),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_idx(fill_idx),
        .fill_wd(fill_wd), .fill_done(fill_done),
        .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_idx(evict_idx),
        .evict_rsp_valid(evict_rsp_valid), .evict_rsp_rd(evict_rsp_rd),
        .ram_a(ram_a), .ram_offset(ram_offset), .ram_be(ram_be), .ram_wd(ram_wd),
        .ram_fill(ram_fill), .ram_write(ram_write), .ram_read(ram_read), .ram_rd(ram_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port array: registered read, garbage whenever no read was issued.
    always @(posedge clk) begin
        if (ram_write) dsram[ram_a[3:0]] <= ram_wd;
        if (ram_read) ram_rd <= dsram[ram_a[3:0]];
        else          ram_rd <= {8{$urandom}};
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] l = '0;
        for (int k = 0; k < 8; k++) l = {l[223:0], 32'($urandom)};
        return l;
    endfunction

    function automatic logic [31:0] ref_word(input logic [3:0] i, input logic [2:0] off);
        logic [255:0] l = ref_mem[i];
        return l[{off, 5'b00000} +: 32];
    endfunction

    // Line as it should look after a store: bytes of the addressed word replaced where enabled.
    function automatic logic [255:0] ref_store(input logic [3:0] i, input logic [2:0] off,
                                               input logic [3:0] be, input logic [31:0] wd);
        logic [255:0] l = ref_mem[i];
        logic [31:0]  w = l[{off, 5'b00000} +: 32];
        for (int b = 0; b < 4; b++) begin
            if (be[b]) w = (w & ~(32'hFF << (8 * b))) | (wd & (32'hFF << (8 * b)));
        end
        l[{off, 5'b00000} +: 32] = w;
        return l;
    endfunction

    function automatic logic grant_of(input int which);
        case (which)
            1:       return fill_ready;
            2:       return evict_ready;
            default: return core_ready;
        endcase
    endfunction

    task automatic wait_grant(input int which, input string tag);
        int n = 0;
        #1;
        while (!grant_of(which) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk1({tag, "_grant"}, grant_of(which), 1'b1);
    endtask

    task automatic do_fill(input logic [3:0] i, input logic [255:0] line);
        fill_valid = 1'b1; fill_idx = 13'(i); fill_wd = line;
        wait_grant(1, "fill");
        @(posedge clk); #1;
        fill_valid = 1'b0;
        chk1("fill_done", fill_done, 1'b1);
        chk1("fill_write", ram_write, 1'b1);
        chk1("fill_ram_fill", ram_fill, 1'b1);
        chk1("fill_no_read", ram_read, 1'b0);
        chk32("fill_addr", 32'(ram_a), 32'(i));
        chk256("fill_wd", ram_wd, line);
        ref_mem[i] = line;
    endtask

    task automatic do_load(input logic [3:0] i, input logic [2:0] off);
        core_valid = 1'b1; core_we = 1'b0; core_idx = 13'(i); core_offset = off;
        core_be = 4'($urandom); core_wd = $urandom;
        wait_grant(0, "load");
        @(posedge clk); #1;
        core_valid = 1'b0;
        chk1("load_read", ram_read, 1'b1);
        chk32("load_addr", 32'(ram_a), 32'(i));
        @(posedge clk); #1;
        chk1("load_rsp_valid", core_rsp_valid, 1'b1);
        chk32("load_data", core_rsp_rd, ref_word(i, off));
    endtask

    task automatic do_store(input logic [3:0] i, input logic [2:0] off,
                            input logic [3:0] be, input logic [31:0] wd);
        logic [255:0] exp_line;
        core_valid = 1'b1; core_we = 1'b1; core_idx = 13'(i); core_offset = off;
        core_be = be; core_wd = wd;
        wait_grant(0, "store");
        @(posedge clk); #1;
        core_valid = 1'b0;
        chk1("store_read", ram_read, 1'b1);
        chk1("store_no_write_t1", ram_write, 1'b0);
        @(posedge clk); #1;
        exp_line = ref_store(i, off, be, wd);
        chk1("store_write", ram_write, 1'b1);
        chk1("store_no_read_t2", ram_read, 1'b0);
        chk32("store_offset", 32'(ram_offset), 32'(off));
        chk32("store_be", 32'(ram_be), 32'(be));
        chk256("store_wd", ram_wd, exp_line);
        chk1("store_ack", core_rsp_valid, 1'b1);
        chk32("store_ack_data", core_rsp_rd, 32'h0);
        ref_mem[i] = exp_line;
        @(posedge clk); #1;
    endtask

    task automatic do_evict(input logic [3:0] i);
        evict_valid = 1'b1; evict_idx = 13'(i);
        wait_grant(2, "evict");
        @(posedge clk); #1;
        evict_valid = 1'b0;
        chk1("evict_read", ram_read, 1'b1);
        chk32("evict_addr", 32'(ram_a), 32'(i));
        @(posedge clk); #1;
        chk1("evict_rsp_valid", evict_rsp_valid, 1'b1);
        chk256("evict_data", evict_rsp_rd, ref_mem[i]);
        @(posedge clk); #1;
    endtask

    // All three requesters raised together; each drops once accepted. Returns grant order.
    task automatic arb_round(output int o0, output int o1, output int o2);
        int order [3];
        int got = 0;
        int n = 0;
        int winner;
        logic [2:0] rr;
        logic [255:0] fl = rnd_line();
        order = '{-1, -1, -1};
        fill_valid = 1'b1; fill_idx = 13'd8; fill_wd = fl;
        evict_valid = 1'b1; evict_idx = 13'd9;
        core_valid = 1'b1; core_we = 1'b0; core_idx = 13'd10; core_offset = 3'd1;
        while (got < 3 && n < 60) begin
            #1;
            winner = -1;
            rr = {evict_ready, fill_ready, core_ready};
            chk1("arb_rd_wr_excl", ram_read & ram_write, 1'b0);
            if (rr != 3'b000) begin
                chk32("arb_onehot", 32'($countones(rr)), 32'd1);
                winner = fill_ready ? 1 : (evict_ready ? 2 : 0);
                order[got] = winner;
                got++;
            end
            @(posedge clk); #1;
            if (winner == 1) begin fill_valid = 1'b0; ref_mem[8] = fl; end
            if (winner == 2) evict_valid = 1'b0;
            if (winner == 0) core_valid = 1'b0;
            n++;
        end
        chk32("arb_complete", 32'(got), 32'd3);
        fill_valid = 1'b0; evict_valid = 1'b0; core_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        o0 = order[0]; o1 = order[1]; o2 = order[2];
    endtask

    initial begin
        logic [255:0] line;
        logic [255:0] orig;
        logic [31:0]  prev_exp;
        int a0, a1, a2;

        rst_n = 1'b0;
        core_valid = 1'b0; core_we = 1'b0; core_idx = '0; core_offset = '0; core_be = '0; core_wd = '0;
        fill_valid = 1'b0; fill_idx = '0; fill_wd = '0;
        evict_valid = 1'b0; evict_idx = '0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_core_rsp_valid", core_rsp_valid, 1'b0);
        chk1("rst_evict_rsp_valid", evict_rsp_valid, 1'b0);
        chk1("rst_fill_done", fill_done, 1'b0);
        chk1("rst_ram_write", ram_write, 1'b0);
        chk1("rst_ram_read", ram_read, 1'b0);
        chk1("rst_ram_fill", ram_fill, 1'b0);
        chk32("rst_ram_a", 32'(ram_a), 32'd0);
        chk256("rst_ram_wd", ram_wd, 256'd0);
        chk32("rst_core_rsp_rd", core_rsp_rd, 32'd0);
        chk256("rst_evict_rsp_rd", evict_rsp_rd, 256'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) do_fill(4'(i), rnd_line());

        line = '0;
        for (int k = 7; k >= 0; k--) line = {line[223:0], 32'h50 + 32'(k)};
        do_fill(4'd5, line);
        do_load(4'd5, 3'd3);
        chk32("dir_load_w3", core_rsp_rd, 32'h53);
        @(posedge clk); #1;
        chk1("dir_rsp_pulse_ends", core_rsp_valid, 1'b0);
        chk32("dir_rsp_hold", core_rsp_rd, 32'h53);

        do_store(4'd5, 3'd2, 4'b0101, 32'hAABBCCDD);
        do_load(4'd5, 3'd2);
        chk32("dir_merge_w2", core_rsp_rd, 32'h00BB00DD);

        orig = ref_mem[5];
        do_store(4'd5, 3'd0, 4'b0000, 32'h12345678);
        do_evict(4'd5);
        chk256("dir_be0_unchanged", evict_rsp_rd, orig);

        arb_round(a0, a1, a2);
        chk32("arb1_first_fill", 32'(a0), 32'd1);
        chk32("arb1_second_evict", 32'(a1), 32'd2);
        chk32("arb1_third_core", 32'(a2), 32'd0);
        arb_round(a0, a1, a2);
        chk32("arb2_first_fill", 32'(a0), 32'd1);

        orig = ref_mem[3];
        core_valid = 1'b1; core_we = 1'b1; core_idx = 13'd3; core_offset = 3'($urandom);
        core_be = 4'hF; core_wd = ~orig[31:0];
        wait_grant(0, "rst_store");
        @(posedge clk); #1;
        core_valid = 1'b0;
        @(posedge clk); #1;
        chk1("rst_mrg_write_before", ram_write, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst_mrg_write_drop", ram_write, 1'b0);
        chk1("rst_mrg_no_ack", core_rsp_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk1("rst_mrg_no_late_ack", core_rsp_valid, 1'b0);
        do_evict(4'd3);
        chk256("rst_mrg_line_kept", evict_rsp_rd, orig);

        prev_exp = '0;
        core_valid = 1'b1; core_we = 1'b0;
        core_idx = 13'($urandom_range(0, 15)); core_offset = 3'($urandom);
        for (int c = 0; c < 12; c++) begin
            #1;
            chk1("b2b_ready", core_ready, (c % 2) == 0);
            chk1("b2b_rd_wr_excl", ram_read & ram_write, 1'b0);
            if (c > 0 && (c % 2) == 0) begin
                chk1("b2b_rsp_valid", core_rsp_valid, 1'b1);
                chk32("b2b_data", core_rsp_rd, prev_exp);
            end
            if (core_ready) prev_exp = ref_word(core_idx[3:0], core_offset);
            @(posedge clk); #1;
            core_idx = 13'($urandom_range(0, 15)); core_offset = 3'($urandom);
        end
        core_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: do_load(4'($urandom_range(0, 15)), 3'($urandom));
                1: do_store(4'($urandom_range(0, 15)), 3'($urandom), 4'($urandom), $urandom);
                2: do_evict(4'($urandom_range(0, 15)));
                default: do_fill(4'($urandom_range(0, 15)), rnd_line());
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
